// File: rtl/hazard_unit_pkg.sv
// Shared core definitions for forwarding selects and result sources.
// Used by the hazard unit, control path and datapath.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_src_t;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit connection bundle between control/datapath and hazard unit.
// master drives stage tags, slave returns stall/flush/forward controls.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    import hazard_unit_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic [1:0]            result_src_e;
    logic                  reg_write_m;
    logic                  reg_write_w;
    logic                  pc_src_e;
    logic                  mem_wait;

    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_w;
    fwd_src_t              forward_a_e;
    fwd_src_t              forward_b_e;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output rs1_d, rs2_d, rd_d, result_src_e,
        output reg_write_m, reg_write_w, pc_src_e, mem_wait,
        input  stall_f, stall_d, flush_d, flush_e,
        input  stall_e, stall_m, flush_w,
        input  forward_a_e, forward_b_e, stall_cycles
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, result_src_e,
        input  reg_write_m, reg_write_w, pc_src_e, mem_wait,
        output stall_f, stall_d, flush_d, flush_e,
        output stall_e, stall_m, flush_w,
        output forward_a_e, forward_b_e, stall_cycles
    );

endinterface

// File: rtl/hazard_unit_forward_sel.sv
// Operand forwarding select for one E-stage source register.
// M beats W; x0 is never forwarded.
module hazard_forward_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output fwd_src_t              sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
    assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (hit_m)
                sel = FWD_M;
            else if (hit_w)
                sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, mem_wait freeze,
// operand forwarding and a saturating stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_unit_if.slave hz
);

    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [REG_ADDR_W-1:0] rd_m;
    logic [REG_ADDR_W-1:0] rd_w;
    logic [CNT_W-1:0]      cnt;

    logic load_use;
    logic stall_fd;
    logic flush_e;
    logic freeze;

    // Internal state is treated as cleared while reset is held.
    assign load_use = !reset
                   && (hz.result_src_e == RESULT_SRC_MEM)
                   && (rd_e != '0)
                   && ((rd_e == hz.rs1_d) || (rd_e == hz.rs2_d));

    assign freeze   = hz.mem_wait;
    assign stall_fd = freeze || (load_use && !hz.pc_src_e);
    assign flush_e  = (load_use || hz.pc_src_e) && !freeze;

    assign hz.stall_f      = stall_fd;
    assign hz.stall_d      = stall_fd;
    assign hz.flush_d      = hz.pc_src_e && !freeze;
    assign hz.flush_e      = flush_e;
    assign hz.stall_e      = freeze;
    assign hz.stall_m      = freeze;
    assign hz.flush_w      = freeze;
    assign hz.stall_cycles = cnt;

    hazard_forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .en          (!reset),
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .sel         (hz.forward_a_e)
    );

    hazard_forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .en          (!reset),
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .sel         (hz.forward_b_e)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_e <= '0;
            rs2_e <= '0;
            rd_e  <= '0;
            rd_m  <= '0;
            rd_w  <= '0;
            cnt   <= '0;
        end else begin
            if (!freeze) begin
                if (flush_e) begin
                    rs1_e <= '0;
                    rs2_e <= '0;
                    rd_e  <= '0;
                end else begin
                    rs1_e <= hz.rs1_d;
                    rs2_e <= hz.rs2_d;
                    rd_e  <= hz.rd_d;
                end
                rd_m <= rd_e;
            end
            rd_w <= freeze ? '0 : rd_m;
            if (stall_fd && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table plus scoreboard queue.
// Counter is narrowed so saturation is reachable in a short run.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct {
        logic [6:0]    st;
        fwd_src_t      fa;
        fwd_src_t      fb;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [1:0]    rsrc;
        logic          rwm;
        logic          rww;
        logic          pcs;
        logic          mw;
        exp_t          exp;
    } vec_t;

    // stall_f stall_d flush_d flush_e stall_e stall_m flush_w
    localparam logic [6:0] ZZ = 7'b0000000;
    localparam logic [6:0] LU = 7'b1101000;
    localparam logic [6:0] BR = 7'b0011000;
    localparam logic [6:0] MW = 7'b1100111;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t tbl[18];

    hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();

    hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input int rs1, input int rs2, input int rd, input int rsrc,
        input int rwm, input int rww, input int pcs, input int mw,
        input logic [6:0] st, input fwd_src_t fa, input fwd_src_t fb,
        input int cnt
    );
        vec_t v;
        v.rs1     = rs1[AW-1:0];
        v.rs2     = rs2[AW-1:0];
        v.rd      = rd[AW-1:0];
        v.rsrc    = rsrc[1:0];
        v.rwm     = rwm[0];
        v.rww     = rww[0];
        v.pcs     = pcs[0];
        v.mw      = mw[0];
        v.exp.st  = st;
        v.exp.fa  = fa;
        v.exp.fb  = fb;
        v.exp.cnt = cnt[CW-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, req);
        end
    endtask

    task automatic compare(input int cyc);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard cycle %0d: got empty expected entry", cyc);
            return;
        end
        n_checks--;
        e = sb.pop_front();
        chk("stall_f", cyc, 32'(hz.stall_f), 32'(e.st[6]));
        chk("stall_d", cyc, 32'(hz.stall_d), 32'(e.st[5]));
        chk("flush_d", cyc, 32'(hz.flush_d), 32'(e.st[4]));
        chk("flush_e", cyc, 32'(hz.flush_e), 32'(e.st[3]));
        chk("stall_e", cyc, 32'(hz.stall_e), 32'(e.st[2]));
        chk("stall_m", cyc, 32'(hz.stall_m), 32'(e.st[1]));
        chk("flush_w", cyc, 32'(hz.flush_w), 32'(e.st[0]));
        chk("forward_a_e", cyc, 32'(hz.forward_a_e), 32'(e.fa));
        chk("forward_b_e", cyc, 32'(hz.forward_b_e), 32'(e.fb));
        chk("stall_cycles", cyc, 32'(hz.stall_cycles), 32'(e.cnt));
    endtask

    // Called at posedge+1: drive, queue expectation, sample on negedge.
    task automatic apply(input vec_t v, input int cyc);
        hz.rs1_d        = v.rs1;
        hz.rs2_d        = v.rs2;
        hz.rd_d         = v.rd;
        hz.result_src_e = v.rsrc;
        hz.reg_write_m  = v.rwm;
        hz.reg_write_w  = v.rww;
        hz.pc_src_e     = v.pcs;
        hz.mem_wait     = v.mw;
        sb.push_back(v.exp);
        @(negedge clk);
        compare(cyc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;

        // Forwarding: M, M over W, W-only, x0
        tbl[0]  = mk( 1,  2,  5, 0, 0, 0, 0, 0, ZZ, FWD_RF, FWD_RF, 0);
        tbl[1]  = mk( 5,  7,  5, 0, 0, 0, 0, 0, ZZ, FWD_RF, FWD_RF, 0);
        tbl[2]  = mk( 5,  0,  5, 0, 1, 0, 0, 0, ZZ, FWD_M,  FWD_RF, 0);
        tbl[3]  = mk( 5,  6,  6, 0, 1, 1, 0, 0, ZZ, FWD_M,  FWD_RF, 0);
        tbl[4]  = mk( 0,  0,  0, 0, 0, 1, 0, 0, ZZ, FWD_W,  FWD_RF, 0);
        tbl[5]  = mk( 0,  0,  7, 0, 1, 0, 0, 0, ZZ, FWD_RF, FWD_RF, 0);
        tbl[6]  = mk( 0,  0,  0, 0, 1, 1, 0, 0, ZZ, FWD_RF, FWD_RF, 0);
        // Load-use: lw x5 then add x6,x5,x1
        tbl[7]  = mk( 1,  0,  5, 0, 1, 0, 0, 0, ZZ, FWD_RF, FWD_RF, 0);
        tbl[8]  = mk( 5,  1,  6, 1, 0, 1, 0, 0, LU, FWD_RF, FWD_RF, 0);
        tbl[9]  = mk( 5,  1,  6, 0, 1, 0, 0, 0, ZZ, FWD_RF, FWD_RF, 1);
        tbl[10] = mk( 2,  0,  8, 0, 0, 1, 0, 0, ZZ, FWD_W,  FWD_RF, 1);
        // Branch taken together with load-use
        tbl[11] = mk( 8,  0,  9, 1, 1, 0, 1, 0, BR, FWD_RF, FWD_RF, 1);
        tbl[12] = mk( 8,  3, 10, 0, 1, 1, 0, 0, ZZ, FWD_RF, FWD_RF, 1);
        tbl[13] = mk(10,  0, 11, 0, 0, 1, 0, 0, ZZ, FWD_W,  FWD_RF, 1);
        // mem_wait x3 with pc_src_e: rd_m held, rd_w flushed
        tbl[14] = mk( 1,  2,  3, 0, 1, 0, 1, 1, MW, FWD_M,  FWD_RF, 1);
        tbl[15] = mk( 1,  2,  3, 0, 0, 1, 1, 1, MW, FWD_RF, FWD_RF, 2);
        tbl[16] = mk( 1,  2,  3, 0, 1, 1, 1, 1, MW, FWD_M,  FWD_RF, 3);
        tbl[17] = mk(11, 11,  6, 0, 1, 0, 0, 0, ZZ, FWD_M,  FWD_RF, 4);

        reset           = 1'b1;
        hz.rs1_d        = '0;
        hz.rs2_d        = '0;
        hz.rd_d         = '0;
        hz.result_src_e = '0;
        hz.reg_write_m  = 1'b0;
        hz.reg_write_w  = 1'b0;
        hz.pc_src_e     = 1'b0;
        hz.mem_wait     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 18; i++)
            apply(tbl[i], i);

        // Long freeze drives the counter into saturation
        for (int k = 0; k < 14; k++) begin
            v = mk(0, 0, 0, 0, 1, 0, 0, 1, MW, FWD_M, FWD_M,
                   (4 + k > 15) ? 15 : 4 + k);
            apply(v, 18 + k);
        end

        // Reset while frozen: forwards gated now, state clear next cycle
        reset = 1'b1;
        v = mk(0, 0, 0, 0, 1, 1, 0, 1, MW, FWD_RF, FWD_RF, 15);
        apply(v, 32);
        reset = 1'b0;
        v = mk(0, 0, 0, 0, 1, 1, 0, 0, ZZ, FWD_RF, FWD_RF, 0);
        apply(v, 33);

        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
